// File: rtl/adc_gray_counter_if.sv
// Handshake and result bus between the ramp ADC Gray counter and its consumer.
// The consumer side (master) requests conversions, supplies the raw comparator
// and acknowledges results; the counter side (slave) returns codes and status.
interface adc_gray_counter_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             comp_in;
  logic             ack;
  logic             ramp_rst;
  logic [WIDTH-1:0] gray_count;
  logic [WIDTH-1:0] gray_value;
  logic             valid;
  logic             busy;
  logic             overflow;

  modport master (
    output start, comp_in, ack,
    input  ramp_rst, gray_count, gray_value, valid, busy, overflow
  );

  modport slave (
    input  start, comp_in, ack,
    output ramp_rst, gray_count, gray_value, valid, busy, overflow
  );
endinterface

// File: rtl/adc_gray_counter.sv
// Single-slope ramp ADC counter. A conversion releases the ramp, counts in
// binary while publishing the count as Gray code, and latches the Gray code
// when the synchronized comparator trips. If the comparator never trips, the
// result saturates at full scale and overflow is flagged. Results are held
// until the consumer acknowledges them.
// SYNC_STAGES must be at least 2 so the comparator is properly synchronized.
module adc_gray_counter #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  adc_gray_counter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] MAX_CNT  = '1;
  localparam logic [WIDTH-1:0] MAX_GRAY = MAX_CNT ^ (MAX_CNT >> 1);

  state_t                 state;
  state_t                 state_next;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   comp_sync;
  logic [WIDTH-1:0]       bin_cnt;
  logic [WIDTH-1:0]       bin_cnt_next;
  logic [WIDTH-1:0]       gray_next;
  logic [WIDTH-1:0]       gray_count_q;
  logic [WIDTH-1:0]       gray_value_q;
  logic [WIDTH-1:0]       gray_value_next;
  logic                   valid_q;
  logic                   valid_next;
  logic                   overflow_q;
  logic                   overflow_next;

  // Shift the asynchronous comparator through a flop chain before the FSM sees it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.comp_in};
    end
  end

  assign comp_sync = sync_q[SYNC_STAGES-1];

  // Register state, counter, published Gray count and latched result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      bin_cnt      <= '0;
      gray_count_q <= '0;
      gray_value_q <= '0;
      valid_q      <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state        <= state_next;
      bin_cnt      <= bin_cnt_next;
      gray_count_q <= gray_next;
      gray_value_q <= gray_value_next;
      valid_q      <= valid_next;
      overflow_q   <= overflow_next;
    end
  end

  // Next-state, counter and result-latch decisions for the conversion sequence
  always_comb begin
    state_next      = state;
    bin_cnt_next    = bin_cnt;
    gray_value_next = gray_value_q;
    valid_next      = valid_q;
    overflow_next   = overflow_q;

    unique case (state)
      IDLE: begin
        bin_cnt_next = '0;
        if (bus.start) begin
          state_next    = RAMP;
          overflow_next = 1'b0;
        end
      end
      RAMP: begin
        if (comp_sync) begin
          gray_value_next = gray_count_q;
          valid_next      = 1'b1;
          overflow_next   = 1'b0;
          state_next      = HOLD;
        end else if (bin_cnt == MAX_CNT) begin
          gray_value_next = MAX_GRAY;
          valid_next      = 1'b1;
          overflow_next   = 1'b1;
          state_next      = HOLD;
        end else begin
          bin_cnt_next = bin_cnt + 1'b1;
        end
      end
      HOLD: begin
        if (bus.ack) begin
          valid_next   = 1'b0;
          bin_cnt_next = '0;
          state_next   = IDLE;
        end
      end
      default: begin
        state_next   = IDLE;
        bin_cnt_next = '0;
      end
    endcase
  end

  // Gray encoding of the next binary count so the registered code tracks bin_cnt exactly
  always_comb begin
    gray_next = bin_cnt_next ^ (bin_cnt_next >> 1);
  end

  assign bus.ramp_rst   = (state != RAMP);
  assign bus.busy       = (state != IDLE);
  assign bus.gray_count = gray_count_q;
  assign bus.gray_value = gray_value_q;
  assign bus.valid      = valid_q;
  assign bus.overflow   = overflow_q;

endmodule

// File: doc/adc_gray_counter.md
ADC_GRAY_COUNTER -- requirements
Module: adc_gray_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, counter and output code width in bits.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, number of flops in the comp_in synchronizer (minimum 2).
REQ-003 SHALL have port clk  input  1  rising-edge system clock.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  conversion request, sampled only in IDLE.
REQ-006 SHALL have port comp_in  input  1  asynchronous ramp comparator output, high = ramp crossed input.
REQ-007 SHALL have port ack  input  1  consumer acknowledge of gray_value, sampled only in HOLD.
REQ-008 SHALL have port ramp_rst  output  1  high = ramp capacitor held discharged.
REQ-009 SHALL have port gray_count  output  WIDTH  live registered Gray count.
REQ-010 SHALL have port gray_value  output  WIDTH  latched Gray conversion result for the downstream Gray-to-binary stage.
REQ-011 SHALL have port valid  output  1  gray_value holds a new result.
REQ-012 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-013 SHALL have port overflow  output  1  result saturated without comparator trip.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, RAMP, HOLD.
REQ-015 SHALL pass comp_in through SYNC_STAGES flops; comp_sync (the last flop) is the only comparator signal used by the FSM.
REQ-016 SHALL keep an internal WIDTH-bit binary counter bin_cnt and register gray_count <= bin_cnt_next ^ (bin_cnt_next >> 1), so gray_count always equals Gray(bin_cnt) and changes at most one bit per cycle.
REQ-017 IDLE: ramp_rst=1, bin_cnt=0, gray_count=0; start=1 SHALL move to RAMP next cycle with bin_cnt=0.
REQ-018 RAMP: ramp_rst=0; each cycle with comp_sync=0 and bin_cnt<max, bin_cnt SHALL increment by 1.
REQ-019 RAMP cycle with comp_sync=1: gray_value <= gray_count (current value), valid <= 1, overflow <= 0, counter frozen, next state HOLD.
REQ-020 RAMP cycle with comp_sync=0 and bin_cnt=2^WIDTH-1: gray_value <= Gray(2^WIDTH-1), valid <= 1, overflow <= 1, next state HOLD; counter SHALL never wrap.
REQ-021 comp_sync=1 at bin_cnt=max SHALL be treated as a trip (REQ-019), overflow=0.
REQ-022 HOLD: ramp_rst=1, gray_value/overflow stable, valid=1 until ack=1; ack=1 SHALL clear valid and move to IDLE next cycle.
REQ-023 start SHALL be ignored in RAMP and HOLD, including start and ack high in the same HOLD cycle (result: IDLE, no new conversion).
REQ-024 ack SHALL be ignored outside HOLD.
REQ-025 overflow SHALL clear on the IDLE-to-RAMP transition; gray_value SHALL hold its last result until the next latch.
REQ-026 Latency: comp_in rising edge (meeting setup) to valid=1 SHALL be SYNC_STAGES+1 clk cycles when in RAMP.
REQ-027 busy SHALL be registered-state-derived: 0 in IDLE, 1 in RAMP and HOLD.

Reset
REQ-028 reset=1 SHALL asynchronously force IDLE, bin_cnt=0, gray_count=0, gray_value=0, valid=0, busy=0, overflow=0, ramp_rst=1, synchronizer flops=0.
REQ-029 reset asserted mid-RAMP or mid-HOLD SHALL abort the conversion with no valid pulse; operation resumes from IDLE on first clk after deassertion.

Verification
REQ-030 Reset check: assert reset mid-RAMP at bin_cnt=40 -> all outputs at REQ-028 values immediately, ramp_rst=1, no valid.
REQ-031 Normal trip: start, comp_in timed so comp_sync=1 when bin_cnt=100 -> gray_value=0x56, valid=1, overflow=0, busy=1 until ack.
REQ-032 Pre-tripped: comp_in held high for >=3 cycles before start -> trip in first RAMP cycle, gray_value=0x00, valid=1.
REQ-033 Overflow: start, comp_in held low -> after 256 RAMP cycles gray_value=0x80, overflow=1, valid=1; next start clears overflow.
REQ-034 Handshake: hold ack low 10 cycles in HOLD -> valid and gray_value stable; then ack=1 with start=1 same cycle -> IDLE, valid=0, busy=0, no RAMP entry.
REQ-035 Gray property: over a full overflow run, gray_count changes exactly one bit per RAMP increment and equals Gray(bin_cnt) every cycle.
